// File: rtl/dcache_line_engine.sv
// Dcache line miss engine: optional dirty-victim writeback from the CAM, then a line refill from the main bus.
// Build option DCACHE_CWF_EN: refill starts at the requested word and wraps (critical word first).
module dcache_line_engine #(
    parameter int LINE_WORDS = 4,
    parameter int INDEX_BITS = 8,
    parameter int TAG_BITS   = 17,
    localparam int OFF_W     = $clog2(LINE_WORDS),
    localparam int AW        = TAG_BITS + INDEX_BITS + OFF_W
) (
    input  logic                        clk_core,
    input  logic                        reset_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_evict,
    input  logic [TAG_BITS-1:0]         req_evict_tag,
    input  logic [TAG_BITS-1:0]         req_tag,
    input  logic [INDEX_BITS-1:0]       req_index,
    input  logic [OFF_W-1:0]            req_word,
    output logic                        cam_read_req,
    output logic [INDEX_BITS+OFF_W-1:0] cam_read_index,
    input  logic [31:0]                 cam_read_data,
    output logic                        cam_write_req_data,
    output logic [INDEX_BITS+OFF_W-1:0] cam_write_index,
    output logic [31:0]                 cam_write_data,
    output logic                        cam_write_req_tag_flags,
    output logic [TAG_BITS-1:0]         cam_write_tag,
    output logic [1:0]                  cam_write_flags,
    output logic                        cvalid,
    input  logic                        cready,
    output logic                        cmd,
    output logic [AW-1:0]               bus_addr,
    output logic                        wvalid,
    input  logic                        wready,
    output logic                        wlast,
    output logic [31:0]                 bus_wdata,
    output logic [3:0]                  wmask,
    input  logic                        rvalid,
    output logic                        rready,
    input  logic                        rlast,
    input  logic [31:0]                 rdata,
    input  logic                        bus_error,
    output logic                        eack,
    output logic                        crit_valid,
    output logic [31:0]                 crit_data,
    output logic                        done,
    output logic                        done_error,
    output logic                        busy,
    output logic [2:0]                  state_dbg
);
    // Handshakes: a transfer occurs in any cycle where valid and ready are both high; a raised valid
    // holds with a stable payload until accepted, except that a bus error drops every valid next cycle.
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_EV_CMD    = 3'd1;
    localparam logic [2:0] S_EV_DATA   = 3'd2;
    localparam logic [2:0] S_FILL_CMD  = 3'd3;
    localparam logic [2:0] S_FILL_DATA = 3'd4;

    localparam logic [OFF_W:0]   CNT_FULL = (OFF_W+1)'(LINE_WORDS);
    localparam logic [OFF_W:0]   CNT_LAST = (OFF_W+1)'(LINE_WORDS - 1);
    localparam logic [OFF_W-1:0] OFS_LAST = OFF_W'(LINE_WORDS - 1);

    logic [2:0]            state_q;
    logic [TAG_BITS-1:0]   tag_q, evict_tag_q;
    logic [INDEX_BITS-1:0] index_q;
    logic [OFF_W-1:0]      word_q, fill_ofs_q, wr_beat_q, start_ofs;
    logic [OFF_W:0]        rd_cnt_q, fill_cnt_q;
    logic [31:0]           wbuf_q;
    logic                  wbuf_valid_q, rd_pending_q;
    logic                  err_evt, w_fire, ev_done, fill_beat, overflow, fill_ok, fill_bad;

`ifdef DCACHE_CWF_EN
    assign start_ofs = word_q;
`else
    assign start_ofs = '0;
`endif

    assign busy      = (state_q != S_IDLE);
    assign req_ready = (state_q == S_IDLE);
    assign err_evt   = busy && bus_error;
    assign eack      = err_evt;
    assign state_dbg = state_q;

    assign cvalid   = (state_q == S_EV_CMD) || (state_q == S_FILL_CMD);
    assign cmd      = (state_q == S_FILL_CMD);
    assign bus_addr = (state_q == S_EV_CMD)   ? {evict_tag_q, index_q, {OFF_W{1'b0}}} :
                      (state_q == S_FILL_CMD) ? {tag_q, index_q, start_ofs} : '0;

    assign wvalid    = (state_q == S_EV_DATA) && wbuf_valid_q;
    assign wlast     = wvalid && (wr_beat_q == OFS_LAST);
    assign bus_wdata = wbuf_q;
    assign wmask     = 4'hF;
    assign w_fire    = wvalid && wready;
    assign ev_done   = w_fire && wlast && !bus_error;

    // One CAM read in flight at a time, so its data always lands in a free word buffer.
    assign cam_read_req   = ((state_q == S_EV_CMD) || (state_q == S_EV_DATA)) && (rd_cnt_q != CNT_FULL)
                            && !rd_pending_q && (!wbuf_valid_q || w_fire);
    assign cam_read_index = {index_q, rd_cnt_q[OFF_W-1:0]};

    assign rready    = (state_q == S_FILL_DATA);
    assign fill_beat = rready && rvalid && !bus_error;
    assign overflow  = fill_beat && (fill_cnt_q == CNT_FULL);
    assign fill_ok   = fill_beat && rlast && (fill_cnt_q == CNT_LAST);
    assign fill_bad  = fill_beat && (overflow || (rlast && (fill_cnt_q != CNT_LAST)));

    assign cam_write_req_data      = fill_beat && !overflow;
    assign cam_write_index         = {index_q, fill_ofs_q};
    assign cam_write_data          = cam_write_req_data ? rdata : '0;
    assign crit_valid              = cam_write_req_data && (fill_ofs_q == word_q);
    assign crit_data               = crit_valid ? rdata : '0;
    assign cam_write_req_tag_flags = err_evt || ev_done || fill_ok || fill_bad;
    assign cam_write_tag           = tag_q;
    assign cam_write_flags         = {1'b0, fill_ok};
    assign done                    = err_evt || fill_ok || fill_bad;
    assign done_error              = err_evt || fill_bad;

    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            tag_q        <= '0;
            evict_tag_q  <= '0;
            index_q      <= '0;
            word_q       <= '0;
            fill_ofs_q   <= '0;
            fill_cnt_q   <= '0;
            wr_beat_q    <= '0;
            rd_cnt_q     <= '0;
            wbuf_q       <= '0;
            wbuf_valid_q <= 1'b0;
            rd_pending_q <= 1'b0;
        end else begin
            rd_pending_q <= cam_read_req;
            if (cam_read_req) rd_cnt_q <= rd_cnt_q + 1'b1;
            if (w_fire) wr_beat_q <= wr_beat_q + 1'b1;
            if (rd_pending_q) begin
                wbuf_q       <= cam_read_data;
                wbuf_valid_q <= 1'b1;
            end else if (w_fire) begin
                wbuf_valid_q <= 1'b0;
            end

            if (err_evt) begin
                state_q      <= S_IDLE;
                wbuf_valid_q <= 1'b0;
                rd_pending_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (req_valid) begin
                        tag_q        <= req_tag;
                        evict_tag_q  <= req_evict_tag;
                        index_q      <= req_index;
                        word_q       <= req_word;
                        rd_cnt_q     <= '0;
                        wr_beat_q    <= '0;
                        wbuf_valid_q <= 1'b0;
                        state_q      <= req_evict ? S_EV_CMD : S_FILL_CMD;
                    end
                    S_EV_CMD:  if (cready) state_q <= S_EV_DATA;
                    S_EV_DATA: if (ev_done) state_q <= S_FILL_CMD;
                    S_FILL_CMD: if (cready) begin
                        fill_ofs_q <= start_ofs;
                        fill_cnt_q <= '0;
                        state_q    <= S_FILL_DATA;
                    end
                    S_FILL_DATA: begin
                        // Offset wraps naturally since LINE_WORDS is a power of two.
                        if (fill_beat && !overflow) begin
                            fill_ofs_q <= fill_ofs_q + 1'b1;
                            fill_cnt_q <= fill_cnt_q + 1'b1;
                        end
                        if (fill_ok || fill_bad) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dcache_line_engine.sv
// Bench for dcache_line_engine: random miss traffic, a reactive bus/CAM model and a queue scoreboard.
module tb_dcache_line_engine;
    localparam int LW         = 4;
    localparam int INDEX_BITS = 8;
    localparam int TAG_BITS   = 17;
    localparam int OFF_W      = $clog2(LW);
    localparam int AW         = TAG_BITS + INDEX_BITS + OFF_W;
    localparam int CW         = INDEX_BITS + OFF_W;
    localparam int BUDGET     = 400;

    logic clk_core = 1'b0;
    logic reset_n;
    logic req_valid, req_ready, req_evict;
    logic [TAG_BITS-1:0] req_evict_tag, req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [OFF_W-1:0] req_word;
    logic cam_read_req;
    logic [CW-1:0] cam_read_index;
    logic [31:0] cam_read_data;
    logic cam_write_req_data;
    logic [CW-1:0] cam_write_index;
    logic [31:0] cam_write_data;
    logic cam_write_req_tag_flags;
    logic [TAG_BITS-1:0] cam_write_tag;
    logic [1:0] cam_write_flags;
    logic cvalid, cready, cmd;
    logic [AW-1:0] bus_addr;
    logic wvalid, wready, wlast;
    logic [31:0] bus_wdata;
    logic [3:0] wmask;
    logic rvalid, rready, rlast;
    logic [31:0] rdata;
    logic bus_error, eack, crit_valid;
    logic [31:0] crit_data;
    logic done, done_error, busy;
    logic [2:0] state_dbg;

    logic [31:0] cam_mem [0:(1<<CW)-1];

    logic [AW:0]         exp_cmd_q[$];
    logic [32:0]         exp_w_q[$];
    logic [CW+31:0]      exp_cw_q[$];
    logic [31:0]         exp_crit_q[$];
    logic [TAG_BITS+2:0] exp_tf_q[$];
    logic [1:0]          exp_done_q[$];
    logic [TAG_BITS+2:0] mon_tf;
    int checks = 0;
    int errors = 0;

    dcache_line_engine #(.LINE_WORDS(LW), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) dut (
        .clk_core(clk_core), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_evict(req_evict),
        .req_evict_tag(req_evict_tag), .req_tag(req_tag), .req_index(req_index), .req_word(req_word),
        .cam_read_req(cam_read_req), .cam_read_index(cam_read_index), .cam_read_data(cam_read_data),
        .cam_write_req_data(cam_write_req_data), .cam_write_index(cam_write_index),
        .cam_write_data(cam_write_data), .cam_write_req_tag_flags(cam_write_req_tag_flags),
        .cam_write_tag(cam_write_tag), .cam_write_flags(cam_write_flags),
        .cvalid(cvalid), .cready(cready), .cmd(cmd), .bus_addr(bus_addr),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .bus_wdata(bus_wdata), .wmask(wmask),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
        .bus_error(bus_error), .eack(eack), .crit_valid(crit_valid), .crit_data(crit_data),
        .done(done), .done_error(done_error), .busy(busy), .state_dbg(state_dbg)
    );

    // Clock and CAM read port (one-cycle read latency, garbage when no read was issued).
    always #5 clk_core = ~clk_core;

    always @(posedge clk_core)
        cam_read_data <= cam_read_req ? cam_mem[cam_read_index] : $urandom;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: output seen with no expected entry", name);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clk_core) begin
        if (reset_n) begin
            if (cvalid && cready) begin
                if (exp_cmd_q.size() == 0) unexpected("bus_cmd");
                else check("bus_cmd", {cmd, bus_addr}, exp_cmd_q.pop_front());
            end
            if (wvalid && wready) begin
                if (exp_w_q.size() == 0) unexpected("write_beat");
                else check("write_beat", {wlast, bus_wdata}, exp_w_q.pop_front());
            end
            if (cam_write_req_data) begin
                if (exp_cw_q.size() == 0) unexpected("cam_data_write");
                else check("cam_data_write", {cam_write_index, cam_write_data}, exp_cw_q.pop_front());
            end
            if (crit_valid) begin
                if (exp_crit_q.size() == 0) unexpected("crit_word");
                else check("crit_word", crit_data, exp_crit_q.pop_front());
            end
            if (cam_write_req_tag_flags) begin
                if (exp_tf_q.size() == 0) unexpected("tag_flags");
                else begin
                    mon_tf = exp_tf_q.pop_front();
                    if (mon_tf[TAG_BITS+2]) check("tag_flags", {cam_write_tag, cam_write_flags}, mon_tf[TAG_BITS+1:0]);
                    else check("flags", cam_write_flags, mon_tf[1:0]);
                end
            end
            if (done) begin
                if (exp_done_q.size() == 0) unexpected("done");
                else check("eack_done_error", {eack, done_error}, exp_done_q.pop_front());
                check("req_ready_during_done", req_ready, 1'b0);
            end
            if (eack && !done) unexpected("eack_without_done");
        end
    end

    task automatic clear_bus();
        req_valid = 0; cready = 0; wready = 0; rvalid = 0; rlast = 0; rdata = 0; bus_error = 0;
    endtask

    task automatic check_drained();
        check("left_cmd", exp_cmd_q.size(), 0);
        check("left_write", exp_w_q.size(), 0);
        check("left_cam_write", exp_cw_q.size(), 0);
        check("left_crit", exp_crit_q.size(), 0);
        check("left_tag_flags", exp_tf_q.size(), 0);
        check("left_done", exp_done_q.size(), 0);
        exp_cmd_q.delete(); exp_w_q.delete(); exp_cw_q.delete();
        exp_crit_q.delete(); exp_tf_q.delete(); exp_done_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_bus();
        repeat (2) @(posedge clk_core);
        @(negedge clk_core);
        check("rst_ctrl", {req_ready, busy, cam_read_req, cam_write_req_data, cam_write_req_tag_flags,
                           cvalid, cmd, wvalid, wlast, rready, eack, crit_valid, done, done_error},
              14'b10_0000_0000_0000);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_cam_write_data", cam_write_data, 0);
        check("rst_crit_data", crit_data, 0);
        check("rst_flags", cam_write_flags, 0);
        check("rst_wmask", wmask, 4'hF);
        check("rst_state", state_dbg, 0);
        @(posedge clk_core); #1;
        reset_n = 1;
    endtask

    // One miss: push the line-level expectations, then act as bus slave until done.
    task automatic run_txn(input logic ev, input logic [TAG_BITS-1:0] etag, input logic [TAG_BITS-1:0] tag,
                           input logic [INDEX_BITS-1:0] idx, input logic [OFF_W-1:0] word,
                           input int rlast_at, input int err_at, input logic stall);
        logic [31:0] rd [0:LW];
        int start;
        int ofs;
        int beat;
        logic fin;
        logic wtog;
        for (int b = 0; b <= LW; b++) rd[b] = $urandom;
`ifdef DCACHE_CWF_EN
        start = int'(word);
`else
        start = 0;
`endif
        if (ev) begin
            exp_cmd_q.push_back({1'b0, etag, idx, {OFF_W{1'b0}}});
            for (int i = 0; i < LW; i++) exp_w_q.push_back({(i == LW - 1), cam_mem[{idx, OFF_W'(i)}]});
            exp_tf_q.push_back('0);
        end
        if (err_at == -2) begin
            exp_tf_q.push_back('0);
            exp_done_q.push_back(2'b11);
        end else begin
            exp_cmd_q.push_back({1'b1, tag, idx, OFF_W'(start)});
            for (int b = 0; b <= LW; b++) begin
                ofs = (start + b) % LW;
                if (b == err_at) begin exp_tf_q.push_back('0); exp_done_q.push_back(2'b11); break; end
                if (b == LW) begin exp_tf_q.push_back('0); exp_done_q.push_back(2'b01); break; end
                exp_cw_q.push_back({idx, OFF_W'(ofs), rd[b]});
                if (ofs == int'(word)) exp_crit_q.push_back(rd[b]);
                if (b == rlast_at) begin
                    if (b == LW - 1) begin exp_tf_q.push_back({1'b1, tag, 2'b01}); exp_done_q.push_back(2'b00); end
                    else begin exp_tf_q.push_back('0); exp_done_q.push_back(2'b01); end
                    break;
                end
            end
        end

        @(posedge clk_core); #1;
        req_evict = ev; req_evict_tag = etag; req_tag = tag; req_index = idx; req_word = word; req_valid = 1;
        @(negedge clk_core);
        check("req_ready_idle", req_ready, 1'b1);
        fin = 0; beat = 0; wtog = 0;
        for (int cyc = 0; cyc < BUDGET && !fin; cyc++) begin
            @(posedge clk_core); #1;
            req_valid = 0; cready = 0; rvalid = 0; rlast = 0; bus_error = 0; rdata = $urandom;
            wtog = ~wtog;
            wready = stall ? wtog : 1'b1;
            if (cvalid) begin
                if (cmd && err_at == -2) bus_error = 1;
                else cready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (rready && (!stall || $urandom_range(0, 3) != 0)) begin
                rvalid = 1;
                rdata = (beat <= LW) ? rd[beat] : 32'h0;
                rlast = (beat == rlast_at);
                bus_error = (beat == err_at);
            end
            @(negedge clk_core);
            if (rvalid && rready) beat++;
            if (done) fin = 1;
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: done not seen within %0d cycles", BUDGET);
            do_reset();
        end else begin
            @(posedge clk_core); #1;
            clear_bus();
            @(negedge clk_core);
            check("req_ready_after_done", req_ready, 1'b1);
            check("busy_after_done", busy, 1'b0);
        end
        check_drained();
    endtask

    // Reset while the refill burst is waiting for data: no done, engine back to idle.
    task automatic reset_mid_burst();
        exp_cmd_q.push_back({1'b1, 17'h0BEEF, 8'h9A, {OFF_W{1'b0}}});
        @(posedge clk_core); #1;
        req_evict = 0; req_tag = 17'h0BEEF; req_index = 8'h9A; req_word = '0; req_valid = 1;
        for (int cyc = 0; cyc < BUDGET && !rready; cyc++) begin
            @(posedge clk_core); #1;
            req_valid = 0;
            cready = cvalid;
            rvalid = 0;
            @(negedge clk_core);
        end
        check("reached_fill_data", rready, 1'b1);
        repeat (3) @(posedge clk_core);
        #1;
        do_reset();
        check_drained();
    endtask

    initial begin
        int m;
        int rl;
        int ea;
        req_evict = 0; req_evict_tag = '0; req_tag = '0; req_index = '0; req_word = '0;
        clear_bus();
        for (int i = 0; i < (1 << CW); i++) cam_mem[i] = $urandom;
        do_reset();

        run_txn(1'b0, 17'h00000, 17'h1ABCD, 8'h12, OFF_W'(2), LW - 1, -1, 1'b0);
        run_txn(1'b1, 17'h00055, 17'h0F0F0, 8'h34, OFF_W'(1), LW - 1, -1, 1'b1);
        run_txn(1'b0, 17'h00000, 17'h12345, 8'h56, OFF_W'(3), LW - 1, -1, 1'b0);
        run_txn(1'b0, 17'h00000, 17'h0AAAA, 8'h78, OFF_W'(0), LW - 1, 1, 1'b0);
        run_txn(1'b0, 17'h00000, 17'h15555, 8'h21, OFF_W'(1), 2, -1, 1'b0);
        run_txn(1'b0, 17'h00000, 17'h03C3C, 8'hF0, OFF_W'(2), LW, -1, 1'b0);
        run_txn(1'b1, 17'h1FFFF, 17'h00001, 8'hFF, OFF_W'(3), LW - 1, -2, 1'b1);
        reset_mid_burst();

        for (int n = 0; n < 40; n++) begin
            m = $urandom_range(0, 9);
            rl = LW - 1;
            ea = -1;
            if (m == 6) ea = $urandom_range(0, LW - 1);
            else if (m == 7) rl = $urandom_range(0, LW - 2);
            else if (m == 8) rl = LW;
            else if (m == 9) ea = -2;
            run_txn(1'($urandom_range(0, 1)), TAG_BITS'($urandom), TAG_BITS'($urandom),
                    INDEX_BITS'($urandom), OFF_W'($urandom), rl, ea, 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
